// File: rtl/cfu_issuer_pkg.sv
// cfu_issuer_pkg: shared types and constants for the CFU command issuer
package cfu_issuer_pkg;
  localparam int FUNC_ID_W = 10;
  localparam int DATA_W = 32;
  localparam logic [DATA_W-1:0] TIMEOUT_DATA = 32'hDEAD_BEEF;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_t;
  typedef struct packed {
    logic [FUNC_ID_W-1:0] function_id;
    logic [DATA_W-1:0] inputs_0;
    logic [DATA_W-1:0] inputs_1;
  } cfu_cmd_t;
  typedef struct packed {
    logic [FUNC_ID_W-1:0] function_id;
    logic [DATA_W-1:0] data;
  } cfu_rsp_t;
endpackage

// File: rtl/cfu_sync_fifo.sv
// cfu_sync_fifo: synchronous fall-through FIFO, power-of-2 depth, active-low sync reset
module cfu_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic do_push, do_pop;
  assign full = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout = mem_q[rd_q];
  // a pop frees the slot a same-cycle push on a full FIFO writes into
  always_comb begin
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    wr_d = wr_q + AW'(do_push);
    rd_d = rd_q + AW'(do_pop);
    cnt_d = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  // storage needs no reset, occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end
endmodule

// File: rtl/cfu_cmd_issuer.sv
// cfu_cmd_issuer: CFU initiator, one command in flight; optional watchdog via CFU_ISSUER_TIMEOUT_EN
module cfu_cmd_issuer
  import cfu_issuer_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FUNC_ID_W-1:0] in_function_id,
  input  logic [DATA_W-1:0]    in_inputs_0,
  input  logic [DATA_W-1:0]    in_inputs_1,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [FUNC_ID_W-1:0] cmd_payload_function_id,
  output logic [DATA_W-1:0]    cmd_payload_inputs_0,
  output logic [DATA_W-1:0]    cmd_payload_inputs_1,
  input  logic                 rsp_valid,
  output logic                 rsp_ready,
  input  logic [DATA_W-1:0]    rsp_payload_outputs_0,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic [FUNC_ID_W-1:0] out_function_id,
  output logic                 busy,
  output logic                 err_timeout
);
  state_t state_q, state_d;
  cfu_cmd_t cmd_q, cmd_d, cmd_head;
  cfu_rsp_t rsp_in, rsp_head;
  logic cmd_full, cmd_empty, cmd_pop, rsp_full, rsp_empty, rsp_push;
`ifdef CFU_ISSUER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmr_q, tmr_d;
  logic err_q, err_d;
  assign err_timeout = err_q;
`else
  assign err_timeout = 1'b0;
`endif
  cfu_sync_fifo #(.W($bits(cfu_cmd_t)), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
    .clk(clk), .reset(reset), .push(in_valid), .din({in_function_id, in_inputs_0, in_inputs_1}),
    .pop(cmd_pop), .dout(cmd_head), .full(cmd_full), .empty(cmd_empty)
  );
  cfu_sync_fifo #(.W($bits(cfu_rsp_t)), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk), .reset(reset), .push(rsp_push), .din(rsp_in),
    .pop(out_ready), .dout(rsp_head), .full(rsp_full), .empty(rsp_empty)
  );
  assign in_ready = !cmd_full;
  assign cmd_valid = state_q == ISSUE;
  assign rsp_ready = state_q == WAIT_RSP;
  assign cmd_payload_function_id = cmd_q.function_id;
  assign cmd_payload_inputs_0 = cmd_q.inputs_0;
  assign cmd_payload_inputs_1 = cmd_q.inputs_1;
  assign out_valid = !rsp_empty;
  assign out_data = rsp_head.data;
  assign out_function_id = rsp_head.function_id;
  assign busy = state_q != IDLE || !cmd_empty;
  // issue only with a response slot reserved, so WAIT_RSP never stalls the responder
  always_comb begin
    state_d = state_q;
    cmd_d = cmd_q;
    cmd_pop = 1'b0;
    rsp_push = 1'b0;
    rsp_in = {cmd_q.function_id, rsp_payload_outputs_0};
`ifdef CFU_ISSUER_TIMEOUT_EN
    err_d = err_q;
    tmr_d = state_q == WAIT_RSP ? tmr_q + TW'(1) : '0;
`endif
    case (state_q)
      IDLE: if (!cmd_empty && (!rsp_full || out_ready)) begin
        cmd_pop = 1'b1;
        cmd_d = cmd_head;
        state_d = ISSUE;
      end
      ISSUE: if (cmd_ready) state_d = WAIT_RSP;
      WAIT_RSP: if (rsp_valid) begin
        rsp_push = 1'b1;
        state_d = IDLE;
      end
`ifdef CFU_ISSUER_TIMEOUT_EN
      else if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
        rsp_push = 1'b1;
        rsp_in.data = TIMEOUT_DATA;
        err_d = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // state, payload and watchdog registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cmd_q <= '0;
`ifdef CFU_ISSUER_TIMEOUT_EN
      tmr_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cmd_q <= cmd_d;
`ifdef CFU_ISSUER_TIMEOUT_EN
      tmr_q <= tmr_d;
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// tb_cfu_cmd_issuer: scoreboard bench for cfu_cmd_issuer with a CFU responder model
module tb_cfu_cmd_issuer;
  logic clk = 0;
  logic reset = 0;
  logic in_valid = 0, in_ready;
  logic [9:0] in_function_id = '0;
  logic [31:0] in_inputs_0 = '0, in_inputs_1 = '0;
  logic cmd_valid, cmd_ready = 1;
  logic [9:0] cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1;
  logic rsp_valid = 0, rsp_ready;
  logic [31:0] rsp_payload_outputs_0 = '0;
  logic out_valid, out_ready = 0;
  logic [31:0] out_data;
  logic [9:0] out_function_id;
  logic busy, err_timeout;
  int n_chk = 0, n_pass = 0, hs_cnt = 0, n_pop = 0;
  logic answer = 1;
  logic [41:0] sb[$];

  cfu_cmd_issuer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_function_id(in_function_id), .in_inputs_0(in_inputs_0), .in_inputs_1(in_inputs_1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_function_id(out_function_id),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [9:0] fid, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp);
    in_valid = 1;
    in_function_id = fid;
    in_inputs_0 = a;
    in_inputs_1 = b;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    chk("push_ready", in_ready, 1);
    tick();
    in_valid = 0;
    sb.push_back({fid, exp});
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !busy && !out_valid) break;
    end
    chk("drain", {sb.size() == 0, busy, out_valid}, 3'b100);
    tick();
  endtask

  // responder: accept at the cmd handshake, answer in the following cycle
  initial begin
    logic chs, rhs;
    logic [31:0] d;
    forever begin
      @(negedge clk);
      chs = cmd_valid && cmd_ready;
      rhs = rsp_valid && rsp_ready;
      d = cmd_payload_inputs_0 + cmd_payload_inputs_1;
      @(posedge clk);
      #1;
      if (chs) hs_cnt++;
      if (rhs) rsp_valid = 0;
      if (chs && answer) begin
        rsp_valid = 1;
        rsp_payload_outputs_0 = d;
      end
    end
  end

  // consumer: compare every popped response with the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        n_pop++;
        if (sb.size() == 0) chk("rsp_unexpected", {out_function_id, out_data}, 64'hFFFF_FFFF_FFFF_FFFF);
        else chk("rsp", {out_function_id, out_data}, sb.pop_front());
      end
    end
  end

  initial begin
    int h0, p0, cnt;
    repeat (3) tick();
    @(negedge clk);
    chk("rst_outs", {cmd_valid, rsp_ready, out_valid, busy, err_timeout, in_ready}, 6'b000001);
    chk("rst_payload", {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} == '0, 1);
    tick();
    reset = 1;
    tick();
    // single command
    push(10'h008, 32'h1, 32'h2, 32'h3);
    chk("lat_n", cmd_valid, 0);
    tick();
    chk("lat_n1", cmd_valid, 1);
    chk("lat_fid", cmd_payload_function_id, 10'h008);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk("single_data", {out_valid, out_function_id, out_data}, {1'b1, 10'h008, 32'h3});
    tick();
    out_ready = 1;
    drain();
    chk("single_busy", busy, 0);
    // stalled cmd_ready
    cmd_ready = 0;
    h0 = hs_cnt;
    p0 = n_pop;
    push(10'h011, 32'h5, 32'h6, 32'hB);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (cmd_valid) break;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_hold", {cmd_valid, cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1},
          {1'b1, 10'h011, 32'h5, 32'h6});
    end
    tick();
    cmd_ready = 1;
    drain();
    chk("stall_hs", hs_cnt - h0, 1);
    chk("stall_rsp", n_pop - p0, 1);
    // burst with a stalled consumer
    out_ready = 0;
    h0 = hs_cnt;
    for (int i = 0; i < 6; i++) push(10'(i), 32'(i * 3), 32'h100, 32'(i * 3) + 32'h100);
    repeat (30) tick();
    chk("burst_issued", hs_cnt - h0, 4);
    chk("burst_rdy", in_ready, 1);
    push(10'd6, 32'h7, 32'h8, 32'hF);
    push(10'd7, 32'h9, 32'h1, 32'hA);
    @(negedge clk);
    chk("burst_full", in_ready, 0);
    tick();
    in_valid = 1;
    in_function_id = 10'h3FF;
    tick();
    in_valid = 0;
    chk("burst_still4", hs_cnt - h0, 4);
    out_ready = 1;
    drain();
    chk("burst_total", hs_cnt - h0, 8);
    // spurious response while idle
    p0 = n_pop;
    rsp_valid = 1;
    rsp_payload_outputs_0 = 32'hFFFF_FFFF;
    @(negedge clk);
    chk("spur_ready", rsp_ready, 0);
    tick();
    rsp_valid = 0;
    @(negedge clk);
    chk("spur_out", out_valid, 0);
    tick();
    chk("spur_pop", n_pop - p0, 0);
    // reset while waiting for a response with two commands queued
    answer = 0;
    push(10'h040, 32'h1, 32'h1, 32'h2);
    push(10'h041, 32'h1, 32'h1, 32'h2);
    push(10'h042, 32'h1, 32'h1, 32'h2);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_ready) break;
    end
    chk("rstmid_wait", rsp_ready, 1);
    tick();
    reset = 0;
    tick();
    @(negedge clk);
    chk("rstmid_outs", {cmd_valid, rsp_ready, out_valid, busy, err_timeout}, 5'b0);
    chk("rstmid_payload", {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} == '0, 1);
    sb.delete();
    tick();
    reset = 1;
    answer = 1;
    h0 = hs_cnt;
    p0 = n_pop;
    repeat (10) tick();
    chk("rstmid_noissue", hs_cnt - h0, 0);
    chk("rstmid_norsp", n_pop - p0, 0);
`ifdef CFU_ISSUER_TIMEOUT_EN
    // watchdog: responder stays silent
    answer = 0;
    out_ready = 0;
    push(10'h020, 32'h4, 32'h4, 32'hDEAD_BEEF);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_ready) break;
    end
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (!rsp_ready) break;
      cnt++;
      @(negedge clk);
    end
    chk("to_cycles", cnt, 8);
    chk("to_flag", {err_timeout, out_valid, out_function_id, out_data}, {1'b1, 1'b1, 10'h020, 32'hDEAD_BEEF});
    answer = 1;
    h0 = hs_cnt;
    tick();
    push(10'h021, 32'h2, 32'h3, 32'h5);
    out_ready = 1;
    drain();
    chk("to_next", hs_cnt - h0, 1);
    chk("to_sticky", err_timeout, 1);
`else
    chk("no_timeout", err_timeout, 0);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
